// File: rtl/ehl_ddr_wrdata_gearbox.sv
// Write-data gearbox: pairs 4-phase DFI write beats into 8-phase PHY bursts, buffers
// them in a small FIFO and presents one reordered burst (data + active-high mask) per PHY request.
module ehl_ddr_wrdata_gearbox #(
  parameter int SDRAM_WIDTH = 16,
  parameter int DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              dfi_wrdata_en,
  input  logic [4*SDRAM_WIDTH-1:0]          dfi_wrdata,
  input  logic [4*(SDRAM_WIDTH/8)-1:0]      dfi_wrdata_mask,
  input  logic                              phy_wrdata_en,
  output logic [8*SDRAM_WIDTH-1:0]          phy_wrdata,
  output logic [8*(SDRAM_WIDTH/8)-1:0]      phy_wrdata_mask,
  input  logic                              clr,
  output logic                              empty,
  output logic [$clog2(DEPTH):0]            level,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int L  = SDRAM_WIDTH / 8;
  localparam int BW = 8 * SDRAM_WIDTH;
  localparam int MW = 8 * L;
  localparam int AW = $clog2(DEPTH);

  logic [BW-1:0]          mem_data [DEPTH];
  logic [MW-1:0]          mem_mask [DEPTH];

  logic [4*SDRAM_WIDTH-1:0] low_data;
  logic [4*L-1:0]           low_mask;
  logic                     half_pend;

  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [BW-1:0] data_q;
  logic [MW-1:0] mask_q;
  logic          uf_blank;

  logic          push_req, push, pop, full, drop, uf_evt;
  logic [BW-1:0] head_data, reord_data;
  logic [MW-1:0] head_mask, reord_mask;

  assign full     = (level == (AW+1)'(DEPTH));
  assign push_req = dfi_wrdata_en & half_pend;
  assign pop      = phy_wrdata_en & ~empty;
  // At full a push only lands if the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign uf_evt   = phy_wrdata_en & empty;

  assign wr_ptr_nxt = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_ptr_nxt = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

  // NOTE: the burst storage has no reset; validity is tracked solely by the pointers,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= {dfi_wrdata, low_data};
      mem_mask[wr_ptr[AW-1:0]] <= {dfi_wrdata_mask, low_mask};
    end
  end

  assign head_data = mem_data[rd_ptr[AW-1:0]];
  assign head_mask = mem_mask[rd_ptr[AW-1:0]];

  // Phase-major burst to lane-major PHY layout; byte enables become active-high masks.
  always_comb begin
    reord_data = '0;
    reord_mask = '0;
    for (int w = 0; w < L; w++) begin
      for (int p = 0; p < 8; p++) begin
        reord_data[w*64 + p*8 +: 8] = head_data[(p*L + w)*8 +: 8];
        reord_mask[w*8 + p]         = ~head_mask[p*L + w];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_pend <= 1'b0;
      low_data  <= '0;
      low_mask  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      empty     <= 1'b1;
      data_q    <= '0;
      mask_q    <= '1;
      uf_blank  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (dfi_wrdata_en) begin
        if (!half_pend) begin
          low_data  <= dfi_wrdata;
          low_mask  <= dfi_wrdata_mask;
        end
        half_pend <= ~half_pend;
      end

      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      level  <= wr_ptr_nxt - rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);

      if (pop) begin
        data_q <= reord_data;
        mask_q <= reord_mask;
      end
      uf_blank <= uf_evt;

      if (drop)     overflow  <= 1'b1;
      else if (clr) overflow  <= 1'b0;
      if (uf_evt)   underflow <= 1'b1;
      else if (clr) underflow <= 1'b0;
    end
  end

  assign phy_wrdata      = data_q;
  // An underflowed request shows a fully masked burst for one cycle so the PHY writes nothing.
  assign phy_wrdata_mask = uf_blank ? '1 : mask_q;

endmodule

// File: tb/tb_ehl_ddr_wrdata_gearbox.sv
// Directed bench for ehl_ddr_wrdata_gearbox (W=16, DEPTH=4): vector table for the
// reorder/mask mapping plus sequences for underflow, full, push/pop collisions and reset.
module tb_ehl_ddr_wrdata_gearbox;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dfi_wrdata_en = 1'b0;
  logic [63:0]   dfi_wrdata = '0;
  logic [7:0]    dfi_wrdata_mask = '0;
  logic          phy_wrdata_en = 1'b0;
  logic [127:0]  phy_wrdata;
  logic [15:0]   phy_wrdata_mask;
  logic          clr = 1'b0;
  logic          empty;
  logic [2:0]    level;
  logic          overflow;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;

  ehl_ddr_wrdata_gearbox #(.SDRAM_WIDTH(16), .DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .dfi_wrdata_en   (dfi_wrdata_en),
    .dfi_wrdata      (dfi_wrdata),
    .dfi_wrdata_mask (dfi_wrdata_mask),
    .phy_wrdata_en   (phy_wrdata_en),
    .phy_wrdata      (phy_wrdata),
    .phy_wrdata_mask (phy_wrdata_mask),
    .clr             (clr),
    .empty           (empty),
    .level           (level),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [63:0]  b0;
    logic [7:0]   m0;
    logic [63:0]  b1;
    logic [7:0]   m1;
    logic [127:0] exp_data;
    logic [15:0]  exp_mask;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] m, input logic req);
    dfi_wrdata_en   = 1'b1;
    dfi_wrdata      = d;
    dfi_wrdata_mask = m;
    phy_wrdata_en   = req;
    step();
    dfi_wrdata_en   = 1'b0;
    phy_wrdata_en   = 1'b0;
  endtask

  task automatic request();
    phy_wrdata_en = 1'b1;
    step();
    phy_wrdata_en = 1'b0;
  endtask

  function automatic logic [63:0] pat_b0(input int i);
    logic [7:0] lo = 8'h10 + 8'(i);
    return {8{lo}};
  endfunction

  function automatic logic [63:0] pat_b1(input int i);
    logic [7:0] hi = 8'h20 + 8'(i);
    return {8{hi}};
  endfunction

  // Uniform beats: each lane gets the beat-0 byte on phases 0-3 and the beat-1 byte on 4-7.
  function automatic logic [127:0] pat_exp(input int i);
    logic [7:0] lo = 8'h10 + 8'(i);
    logic [7:0] hi = 8'h20 + 8'(i);
    return {2{{4{hi}}, {4{lo}}}};
  endfunction

  task automatic push_pair(input int i);
    beat(pat_b0(i), 8'hFF, 1'b0);
    beat(pat_b1(i), 8'hFF, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"byte_index", 64'h0706050403020100, 8'hFF, 64'h0F0E0D0C0B0A0908, 8'hFF,
                128'h0F0D0B09070503010E0C0A0806040200, 16'h0000};
    vecs[1] = '{"beat1_half_en", 64'h0706050403020100, 8'hFF, 64'h0F0E0D0C0B0A0908, 8'h0F,
                128'h0F0D0B09070503010E0C0A0806040200, 16'hC0C0};
    vecs[2] = '{"beat0_masked", 64'h0000000000000000, 8'h00, 64'hFFFFFFFFFFFFFFFF, 8'hFF,
                128'hFFFFFFFF00000000FFFFFFFF00000000, 16'h0F0F};
    vecs[3] = '{"lane_split_en", 64'h1122334455667788, 8'h55, 64'h99AABBCCDDEEFF00, 8'hAA,
                128'h99BBDDFF11335577AACCEE0022446688, 16'h0FF0};

    step();
    step();
    check("rst_data", phy_wrdata, 128'h0);
    check("rst_mask", phy_wrdata_mask, 16'hFFFF);
    check("rst_empty", empty, 1'b1);
    check("rst_level", level, 3'd0);
    check("rst_flags", {overflow, underflow}, 2'b00);
    reset = 1'b0;
    step();

    foreach (vecs[k]) begin
      beat(vecs[k].b0, vecs[k].m0, 1'b0);
      check({vecs[k].name, "_half_level"}, level, 3'd0);
      beat(vecs[k].b1, vecs[k].m1, 1'b0);
      check({vecs[k].name, "_level"}, level, 3'd1);
      check({vecs[k].name, "_empty"}, empty, 1'b0);
      request();
      check({vecs[k].name, "_data"}, phy_wrdata, vecs[k].exp_data);
      check({vecs[k].name, "_mask"}, phy_wrdata_mask, vecs[k].exp_mask);
      check({vecs[k].name, "_drained"}, {empty, level}, {1'b1, 3'd0});
    end

    // Request while empty: one fully masked cycle, data untouched, sticky flag.
    request();
    check("uf_flag", underflow, 1'b1);
    check("uf_mask", phy_wrdata_mask, 16'hFFFF);
    check("uf_data", phy_wrdata, vecs[3].exp_data);
    step();
    check("uf_mask_restore", phy_wrdata_mask, 16'h0FF0);
    check("uf_sticky", underflow, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("uf_clr", underflow, 1'b0);

    // Completing a burst in the same cycle as a request at empty: not visible yet.
    beat(pat_b0(0), 8'hFF, 1'b0);
    beat(pat_b1(0), 8'hFF, 1'b1);
    check("pp_empty_uf", underflow, 1'b1);
    check("pp_empty_level", level, 3'd1);
    check("pp_empty_mask", phy_wrdata_mask, 16'hFFFF);
    clr = 1'b1;
    request();
    clr = 1'b0;
    check("pp_empty_pop", phy_wrdata, pat_exp(0));
    check("pp_empty_clr", underflow, 1'b0);

    // Five bursts into a four-deep FIFO: the fifth is dropped.
    for (int i = 0; i < 5; i++) push_pair(i);
    check("ovf_level", level, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_half_clear", dut.half_pend, 1'b0);
    for (int i = 0; i < 4; i++) begin
      request();
      check($sformatf("ovf_pop%0d_data", i), phy_wrdata, pat_exp(i));
      check($sformatf("ovf_pop%0d_mask", i), phy_wrdata_mask, 16'h0000);
    end
    check("ovf_drained", {empty, level}, {1'b1, 3'd0});
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);

    // Full FIFO, new burst completes alongside a request: both succeed.
    for (int i = 0; i < 4; i++) push_pair(i);
    beat(pat_b0(4), 8'hFF, 1'b0);
    beat(pat_b1(4), 8'hFF, 1'b1);
    check("full_pp_ovf", overflow, 1'b0);
    check("full_pp_level", level, 3'd4);
    check("full_pp_data", phy_wrdata, pat_exp(0));
    for (int i = 1; i < 5; i++) begin
      request();
      check($sformatf("full_pp_pop%0d", i), phy_wrdata, pat_exp(i));
    end
    check("full_pp_empty", empty, 1'b1);

    // Reset in the middle of a cycle with a half burst pending.
    beat(pat_b0(7), 8'hFF, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data", phy_wrdata, 128'h0);
    check("mid_rst_mask", phy_wrdata_mask, 16'hFFFF);
    check("mid_rst_fifo", {empty, level}, {1'b1, 3'd0});
    check("mid_rst_half", dut.half_pend, 1'b0);
    reset = 1'b0;
    step();
    push_pair(8);
    check("post_rst_level", level, 3'd1);
    request();
    check("post_rst_data", phy_wrdata, pat_exp(8));
    check("post_rst_mask", phy_wrdata_mask, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
